// File: rtl/probe_write_arbiter.sv
// Round-robin arbiter feeding one probe-buffer write port through a small FIFO, with a capture FSM.
// Optional PROBE_ARB_TAG_EN: replaces the top $clog2(NUM_REQ) bits of pb_write with the requester index.
module probe_write_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          clear,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]     req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_W-1:0]             pb_write,
  output logic                          pb_wen,
  input  logic                          pb_ready,
  output logic [1:0]                    state_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [31:0]                   accept_cnt,
  output logic                          done
);

  localparam int unsigned PtrW  = $clog2(NUM_REQ);
  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW  = AddrW + 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [PtrW-1:0]   rr_q, rr_d;
  logic [AddrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LvlW-1:0]   level_q, level_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

  logic              empty, full, out_active, pop, push, arb_en, found;
  logic [PtrW-1:0]   grant_idx;
  int unsigned       cand;
  logic [DATA_W-1:0] push_data, head_word;

  assign empty      = (level_q == '0);
  assign full       = (level_q == LvlW'(FIFO_DEPTH));
  assign out_active = (state_q == StRun) || (state_q == StDrain);
  // Reset gates both sides so nothing moves in the reset cycle itself.
  assign pop        = !reset && !empty && pb_ready && out_active;
  assign arb_en     = !reset && (state_q == StRun) && (!full || pop);

  always_comb begin
    req_ready = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(rr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (arb_en && !found && req_valid[PtrW'(cand)]) begin
        found                   = 1'b1;
        grant_idx               = PtrW'(cand);
        req_ready[PtrW'(cand)]  = 1'b1;
      end
    end
  end

  assign push = found;

  always_comb begin
    push_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) push_data = req_data[i*DATA_W +: DATA_W];
    end
  end

`ifdef PROBE_ARB_TAG_EN
  logic [PtrW-1:0] tag_q [FIFO_DEPTH];

  always_ff @(posedge clock) begin
    if (push) tag_q[wptr_q] <= grant_idx;
  end

  assign head_word = {tag_q[rptr_q], mem_q[rptr_q][DATA_W-PtrW-1:0]};
`else
  assign head_word = mem_q[rptr_q];
`endif

  assign pb_wen   = pop;
  assign pb_write = pop ? head_word : '0;

  always_comb begin
    wptr_d  = push ? wptr_q + AddrW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + AddrW'(1) : rptr_q;
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
    rr_d = rr_q;
    if (push) rr_d = (grant_idx == PtrW'(NUM_REQ - 1)) ? '0 : grant_idx + PtrW'(1);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (push && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun:   if (stop) state_d = StDrain;
      StDrain: if (level_d == '0) state_d = StDone;
      StDone:  if (clear) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      rr_q    <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and level.
  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q] <= push_data;
  end

  assign state_o    = state_q;
  assign fifo_level = level_q;
  assign accept_cnt = cnt_q;
  assign done       = (state_q == StDone);

endmodule

// File: tb/tb_probe_write_arbiter.sv
// Self-checking bench for probe_write_arbiter: directed vector table, corner sequences, random vs model.
module tb_probe_write_arbiter;
  localparam int NR = 4;
  localparam int DW = 64;
  localparam int FD = 8;

  logic             clock = 1'b0;
  logic             reset, start, stop, clear, pb_ready, pb_wen, done;
  logic [NR-1:0]    req_valid, req_ready;
  logic [NR*DW-1:0] req_data;
  logic [DW-1:0]    pb_write;
  logic [1:0]       state_o;
  logic [3:0]       fifo_level;
  logic [31:0]      accept_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  probe_write_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .FIFO_DEPTH(FD)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .clear      (clear),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .pb_write   (pb_write),
    .pb_wen     (pb_wen),
    .pb_ready   (pb_ready),
    .state_o    (state_o),
    .fifo_level (fifo_level),
    .accept_cnt (accept_cnt),
    .done       (done)
  );

  typedef struct {
    logic        st, sp, cl;
    logic [3:0]  v;
    logic        pr;
    logic [3:0]  e_rdy;
    logic        e_wen;
    logic [63:0] e_wr;
    logic [1:0]  e_st;
    int          e_lvl;
    int          e_cnt;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_word(input int idx, input logic [63:0] d);
    logic [63:0] r;
    r = d;
`ifdef PROBE_ARB_TAG_EN
    r[63:62] = idx[1:0];
`endif
    return r;
  endfunction

  function automatic vec_t mk(input logic st, input logic sp, input logic cl, input logic [3:0] v,
                              input logic pr, input logic [3:0] rdy, input logic wen,
                              input logic [63:0] wr, input logic [1:0] s, input int lvl,
                              input int cnt);
    vec_t t;
    t.st = st; t.sp = sp; t.cl = cl; t.v = v; t.pr = pr;
    t.e_rdy = rdy; t.e_wen = wen; t.e_wr = wr; t.e_st = s; t.e_lvl = lvl; t.e_cnt = cnt;
    return t;
  endfunction

  function automatic logic [63:0] w(input int i);
    return exp_word(i, 64'h1000 + 64'(i));
  endfunction

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic idle_inputs();
    start = 0; stop = 0; clear = 0; req_valid = '0; pb_ready = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    idle_inputs();
    cyc();
    cyc();
    reset = 0;
  endtask

  task automatic set_data(input int i, input logic [63:0] v);
    req_data[i*DW +: DW] = v;
  endtask

  // From a fresh reset: start, then fill the FIFO with n words from requester r (pb_ready low).
  task automatic start_and_fill(input int r, input int n);
    int c;
    start = 1;
    cyc();
    start = 0;
    pb_ready = 0;
    req_valid = '0;
    req_valid[r] = 1'b1;
    for (c = 0; c < 20; c++) begin
      if (fifo_level == 4'(n)) break;
      cyc();
    end
    req_valid = '0;
    chk("fill_level", 64'(fifo_level), 64'(n));
  endtask

  // Behavioural model state
  int          m_st, m_ptr;
  logic [31:0] m_cnt;
  logic [63:0] m_q [$];

  initial begin
    req_data = '0;
    do_reset();

    // Directed table: start+stop together, round-robin, drain, clear in DRAIN ignored.
    for (int i = 0; i < NR; i++) set_data(i, 64'h1000 + 64'(i));
    tbl[0]  = mk(1, 1, 0, 4'hF, 1, 4'b0000, 0, 0,    2'd0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 4'hF, 1, 4'b0001, 0, 0,    2'd1, 0, 0);
    tbl[2]  = mk(0, 0, 0, 4'hF, 1, 4'b0010, 1, w(0), 2'd1, 1, 1);
    tbl[3]  = mk(0, 0, 0, 4'hF, 1, 4'b0100, 1, w(1), 2'd1, 1, 2);
    tbl[4]  = mk(0, 0, 0, 4'hF, 1, 4'b1000, 1, w(2), 2'd1, 1, 3);
    tbl[5]  = mk(0, 0, 0, 4'hF, 1, 4'b0001, 1, w(3), 2'd1, 1, 4);
    tbl[6]  = mk(0, 0, 0, 4'hF, 1, 4'b0010, 1, w(0), 2'd1, 1, 5);
    tbl[7]  = mk(0, 0, 0, 4'hF, 1, 4'b0100, 1, w(1), 2'd1, 1, 6);
    tbl[8]  = mk(0, 0, 0, 4'hF, 1, 4'b1000, 1, w(2), 2'd1, 1, 7);
    tbl[9]  = mk(0, 1, 0, 4'h0, 1, 4'b0000, 1, w(3), 2'd1, 1, 8);
    tbl[10] = mk(0, 0, 1, 4'h0, 1, 4'b0000, 0, 0,    2'd2, 0, 8);
    tbl[11] = mk(0, 0, 0, 4'h0, 1, 4'b0000, 0, 0,    2'd3, 0, 8);
    tbl[12] = mk(0, 0, 1, 4'h0, 1, 4'b0000, 0, 0,    2'd3, 0, 8);
    tbl[13] = mk(0, 0, 0, 4'h0, 1, 4'b0000, 0, 0,    2'd0, 0, 8);
    for (int i = 0; i < 14; i++) begin
      start = tbl[i].st; stop = tbl[i].sp; clear = tbl[i].cl;
      req_valid = tbl[i].v; pb_ready = tbl[i].pr;
      #1;
      chk($sformatf("tbl%0d_ready", i), 64'(req_ready), 64'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_wen", i), 64'(pb_wen), 64'(tbl[i].e_wen));
      chk($sformatf("tbl%0d_write", i), pb_write, tbl[i].e_wr);
      chk($sformatf("tbl%0d_state", i), 64'(state_o), 64'(tbl[i].e_st));
      chk($sformatf("tbl%0d_level", i), 64'(fifo_level), 64'(tbl[i].e_lvl));
      chk($sformatf("tbl%0d_cnt", i), 64'(accept_cnt), 64'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_done", i), 64'(done), 64'(tbl[i].e_st == 2'd3));
      cyc();
    end
    idle_inputs();

    // Full FIFO: exactly 8 accepts with pb_ready low, then ordered drain A0..A7.
    begin
      int k, n;
      do_reset();
      start = 1;
      cyc();
      start = 0;
      req_valid = 4'b0100;
      k = 0;
      set_data(2, 64'hA0);
      for (int c = 0; c < 12; c++) begin
        #1;
        if (req_ready[2]) k++;
        cyc();
        set_data(2, 64'hA0 + 64'(k));
      end
      chk("full_accepts", 64'(k), 64'd8);
      chk("full_level", 64'(fifo_level), 64'd8);
      #1;
      chk("full_ready", 64'(req_ready), 64'd0);
      chk("full_cnt", 64'(accept_cnt), 64'd8);
      req_valid = '0;
      pb_ready = 1;
      n = 0;
      for (int c = 0; c < 12; c++) begin
        #1;
        if (pb_wen) begin
          chk($sformatf("full_order%0d", n), pb_write, exp_word(2, 64'hA0 + 64'(n)));
          n++;
        end
        cyc();
      end
      chk("full_writes", 64'(n), 64'd8);
      idle_inputs();
    end

    // Drain: level 5, stop, then exactly 5 writes, DONE the cycle after the last pop, clear.
    begin
      int nw, ng;
      do_reset();
      start_and_fill(0, 5);
      stop = 1;
      cyc();
      stop = 0;
      chk("drain_state", 64'(state_o), 64'd2);
      pb_ready = 1;
      req_valid = 4'hF;
      nw = 0;
      ng = 0;
      for (int c = 0; c < 12 && nw < 5; c++) begin
        #1;
        if (req_ready != '0) ng++;
        if (pb_wen) nw++;
        cyc();
      end
      chk("drain_writes", 64'(nw), 64'd5);
      chk("drain_grants", 64'(ng), 64'd0);
      chk("drain_done_state", 64'(state_o), 64'd3);
      chk("drain_done", 64'(done), 64'd1);
      req_valid = '0;
      clear = 1;
      cyc();
      clear = 0;
      chk("clear_state", 64'(state_o), 64'd0);
      chk("clear_done", 64'(done), 64'd0);
    end

    // Reset while RUN with 6 queued words.
    do_reset();
    start_and_fill(1, 6);
    reset = 1;
    pb_ready = 1;
    #1;
    chk("rst_cycle_wen", 64'(pb_wen), 64'd0);
    cyc();
    reset = 0;
    pb_ready = 0;
    chk("rst_state", 64'(state_o), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_cnt", 64'(accept_cnt), 64'd0);
    #1;
    chk("rst_wen", 64'(pb_wen), 64'd0);
    start = 1;
    cyc();
    start = 0;
    chk("rst_restart_state", 64'(state_o), 64'd1);
    chk("rst_restart_level", 64'(fifo_level), 64'd0);
    chk("rst_restart_cnt", 64'(accept_cnt), 64'd0);

    // Tag field: requester 3 word.
    do_reset();
    start = 1;
    cyc();
    start = 0;
    pb_ready = 1;
    req_valid = 4'b1000;
    set_data(3, 64'h0FFF_FFFF_FFFF_FFFF);
    #1;
    chk("tag_ready", 64'(req_ready), 64'b1000);
    cyc();
    req_valid = '0;
    #1;
    chk("tag_wen", 64'(pb_wen), 64'd1);
`ifdef PROBE_ARB_TAG_EN
    chk("tag_write", pb_write, 64'hCFFF_FFFF_FFFF_FFFF);
`else
    chk("tag_write", pb_write, 64'h0FFF_FFFF_FFFF_FFFF);
`endif

    // Random traffic against a queue-based model.
    do_reset();
    m_st = 0; m_ptr = 0; m_cnt = 0; m_q.delete();
    for (int t = 0; t < 1500; t++) begin
      int          g;
      logic        e_pop;
      logic [3:0]  e_rdy;
      logic [63:0] e_wr;
      reset = ($urandom_range(0, 99) == 0);
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 29) == 0);
      clear = ($urandom_range(0, 3) == 0);
      req_valid = 4'($urandom);
      pb_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NR; i++) set_data(i, {$urandom, $urandom});
      #1;
      g = -1;
      if (reset) begin
        chk("rnd_reset_wen", 64'(pb_wen), 64'd0);
      end else begin
        e_pop = (m_q.size() > 0) && pb_ready && (m_st == 1 || m_st == 2);
        e_rdy = '0;
        if (m_st == 1 && (m_q.size() < FD || e_pop)) begin
          for (int k = 0; k < NR; k++) begin
            if (g < 0 && req_valid[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
          end
        end
        if (g >= 0) e_rdy[g] = 1'b1;
        e_wr = e_pop ? m_q[0] : 64'd0;
        chk("rnd_ready", 64'(req_ready), 64'(e_rdy));
        chk("rnd_wen", 64'(pb_wen), 64'(e_pop));
        chk("rnd_write", pb_write, e_wr);
        chk("rnd_state", 64'(state_o), 64'(m_st));
        chk("rnd_level", 64'(fifo_level), 64'(m_q.size()));
        chk("rnd_cnt", 64'(accept_cnt), 64'(m_cnt));
        chk("rnd_done", 64'(done), 64'(m_st == 3));
        if (e_pop) void'(m_q.pop_front());
        if (g >= 0) begin
          m_q.push_back(exp_word(g, req_data[g*DW +: DW]));
          m_ptr = (g + 1) % NR;
          if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
        end
        if (m_st == 0 && start) begin
          m_st = 1;
          m_cnt = 0;
        end else if (m_st == 1 && stop) begin
          m_st = 2;
        end else if (m_st == 2 && m_q.size() == 0) begin
          m_st = 3;
        end else if (m_st == 3 && clear) begin
          m_st = 0;
        end
      end
      cyc();
      if (reset) begin
        m_st = 0; m_ptr = 0; m_cnt = 0; m_q.delete();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
